// File: rtl/food_seller_pkg.sv
// Shared types and tables for the food seller transaction controller.
// Contents:
//   state_e    - sequencer FSM states
//   status_e   - one-cycle status codes driven on vend_sequencer.status
//   NUM_ITEMS  - number of sellable items (codes 1..7, code 0 = no selection)
//   price()    - fixed price table indexed by item code
package food_seller_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    CHECK    = 3'd2,
    DISPENSE = 3'd3,
    CHANGE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    STATUS_OK       = 2'd0,
    STATUS_SOLD_OUT = 2'd1,
    STATUS_NO_FUNDS = 2'd2,
    STATUS_COIN_REJ = 2'd3
  } status_e;

  localparam int NUM_ITEMS = 7;

  // Item 0 is "no selection" and has no price.
  function automatic logic [2:0] price(input logic [2:0] item);
    case (item)
      3'd1:    price = 3'd3;
      3'd2:    price = 3'd4;
      3'd3:    price = 3'd5;
      3'd4:    price = 3'd6;
      3'd5:    price = 3'd2;
      3'd6:    price = 3'd7;
      3'd7:    price = 3'd1;
      default: price = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_stock_table.sv
// Per-item stock counters for the food seller.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset (stock -> STOCK_INIT)
//   dec_valid      - take one unit of dec_item (ignored if that item is empty)
//   dec_item       - item code to decrement (1..7)
//   restock_valid  - reload restock_item to STOCK_INIT; beats a same-cycle decrement
//   restock_item   - item code to reload (0 ignored)
//   available      - registered bitmap, bit i-1 set when item i has stock
module vend_stock_table
  import food_seller_pkg::*;
#(
  parameter int ITEM_W     = 3,
  parameter int STOCK_W    = 2,
  parameter int STOCK_INIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid,
  input  logic [ITEM_W-1:0]    dec_item,
  input  logic                 restock_valid,
  input  logic [ITEM_W-1:0]    restock_item,
  output logic [NUM_ITEMS-1:0] available
);

  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_d [NUM_ITEMS];

  // Array slot i holds item code i+1, so code 0 never matches any slot.
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      stock_d[i] = stock_q[i];
      if (restock_valid && restock_item == ITEM_W'(i + 1)) begin
        stock_d[i] = STOCK_W'(STOCK_INIT);
      end else if (dec_valid && dec_item == ITEM_W'(i + 1) && stock_q[i] != '0) begin
        stock_d[i] = stock_q[i] - STOCK_W'(1);
      end
    end
  end

  // available is built from the next-state counts so it always agrees
  // with the stock registers in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i]   <= STOCK_W'(STOCK_INIT);
        available[i] <= (STOCK_INIT != 0);
      end
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i]   <= stock_d[i];
        available[i] <= (stock_d[i] != '0);
      end
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Transaction controller for the food seller: collects coins into a credit,
// validates a selection against price and stock, sequences dispense and
// change return, and owns the stock table.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   coin_valid, coin_value      - coin strobe and value 1..7 (0 ignored)
//   choice_valid, choice        - selection strobe and item (0 ignored)
//   cancel                      - abort and return all credit
//   restock_valid, restock_item - reload one item's stock
//   item, item_valid            - dispense strobe, item is 0 when not dispensing
//   change, change_valid        - change chunk, 0 when not valid
//   credit                      - current credit
//   available                   - bit i-1 set when item i is in stock
//   status                      - one-cycle flag: OK / SOLD_OUT / NO_FUNDS / COIN_REJ
//   busy                        - FSM is in CHECK, DISPENSE or CHANGE
//   dbg_state                   - current FSM state, for observation only
// Handshake: every input is a single-cycle valid strobe with no ready; a strobe
// is consumed or dropped in the cycle it is sampled and is never held over.
// Every output is a register.
module vend_sequencer
  import food_seller_pkg::*;
#(
  parameter int ITEM_W       = 3,
  parameter int CREDIT_W     = 5,
  parameter int MAX_CREDIT   = 31,
  parameter int STOCK_W      = 2,
  parameter int STOCK_INIT   = 3,
  parameter int DISPENSE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 coin_valid,
  input  logic [2:0]           coin_value,
  input  logic                 choice_valid,
  input  logic [ITEM_W-1:0]    choice,
  input  logic                 cancel,
  input  logic                 restock_valid,
  input  logic [ITEM_W-1:0]    restock_item,
  output logic [ITEM_W-1:0]    item,
  output logic                 item_valid,
  output logic [2:0]           change,
  output logic                 change_valid,
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] available,
  output logic [1:0]           status,
  output logic                 busy,
  output state_e               dbg_state
);

  localparam int CNT_W = (DISPENSE_CYC > 1) ? $clog2(DISPENSE_CYC) : 1;

  state_e              state_q, state_d;
  logic [ITEM_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]    disp_cnt_q, disp_cnt_d;
  logic [CREDIT_W-1:0] credit_d;
  logic [ITEM_W-1:0]   item_d;
  logic                item_valid_d;
  logic [2:0]          change_d;
  logic                change_valid_d;
  status_e             status_d;
  logic                dec_valid;

  // One extra bit so a coin pushing the credit past the ceiling is visible.
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_present;
  logic                coin_fits;
  logic [2:0]          chunk;
  logic [NUM_ITEMS:0]  avail_ext;

  assign coin_present = coin_valid && (coin_value != 3'd0);
  assign coin_sum     = {1'b0, credit} + (CREDIT_W + 1)'(coin_value);
  assign coin_fits    = (coin_sum <= (CREDIT_W + 1)'(MAX_CREDIT));
  assign chunk        = (credit > CREDIT_W'(7)) ? 3'd7 : credit[2:0];
  // Shifted by one so the item code indexes it directly.
  assign avail_ext    = {available, 1'b0};
  assign dbg_state    = state_q;

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    disp_cnt_d     = disp_cnt_q;
    credit_d       = credit;
    item_d         = '0;
    item_valid_d   = 1'b0;
    change_d       = 3'd0;
    change_valid_d = 1'b0;
    status_d       = STATUS_OK;
    dec_valid      = 1'b0;

    // Outside IDLE/COLLECT a coin is never taken; flag it. CHECK may
    // overwrite this below with its own failure code.
    if (coin_present && (state_q == CHECK || state_q == DISPENSE || state_q == CHANGE)) begin
      status_d = STATUS_COIN_REJ;
    end

    case (state_q)
      IDLE: begin
        if (coin_present) begin
          if (coin_fits) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = COLLECT;
          end else begin
            status_d = STATUS_COIN_REJ;
          end
        end
      end

      COLLECT: begin
        // A same-cycle coin lands before cancel or choice is acted on.
        if (coin_present) begin
          if (coin_fits) credit_d = coin_sum[CREDIT_W-1:0];
          else           status_d = STATUS_COIN_REJ;
        end
        if (cancel) begin
          state_d = (credit_d == '0) ? IDLE : CHANGE;
        end else if (choice_valid && choice != '0) begin
          sel_d   = choice;
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (!avail_ext[3'(sel_q)]) begin
          status_d = STATUS_SOLD_OUT;
          state_d  = COLLECT;
        end else if (credit < CREDIT_W'(price(3'(sel_q)))) begin
          status_d = STATUS_NO_FUNDS;
          state_d  = COLLECT;
        end else begin
          credit_d     = credit - CREDIT_W'(price(3'(sel_q)));
          dec_valid    = 1'b1;
          item_d       = sel_q;
          item_valid_d = 1'b1;
          disp_cnt_d   = CNT_W'(DISPENSE_CYC - 1);
          state_d      = DISPENSE;
        end
      end

      DISPENSE: begin
        // item_valid was raised on entry; disp_cnt counts the cycles left.
        if (disp_cnt_q == '0) begin
          state_d = (credit != '0) ? CHANGE : IDLE;
        end else begin
          disp_cnt_d   = disp_cnt_q - CNT_W'(1);
          item_d       = sel_q;
          item_valid_d = 1'b1;
        end
      end

      CHANGE: begin
        change_d       = chunk;
        change_valid_d = 1'b1;
        credit_d       = credit - CREDIT_W'(chunk);
        if (credit <= CREDIT_W'(7)) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      disp_cnt_q   <= '0;
      credit       <= '0;
      item         <= '0;
      item_valid   <= 1'b0;
      change       <= 3'd0;
      change_valid <= 1'b0;
      status       <= STATUS_OK;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      disp_cnt_q   <= disp_cnt_d;
      credit       <= credit_d;
      item         <= item_d;
      item_valid   <= item_valid_d;
      change       <= change_d;
      change_valid <= change_valid_d;
      status       <= status_d;
      busy         <= (state_d == CHECK) || (state_d == DISPENSE) || (state_d == CHANGE);
    end
  end

  vend_stock_table #(
    .ITEM_W    (ITEM_W),
    .STOCK_W   (STOCK_W),
    .STOCK_INIT(STOCK_INIT)
  ) u_stock (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (dec_valid),
    .dec_item     (sel_q),
    .restock_valid(restock_valid),
    .restock_item (restock_item),
    .available    (available)
  );

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: scenario tasks drive strobes and check inline;
// a scoreboard queue holds the expected dispense/change events, which a
// negedge monitor pops and compares as the DUT emits them.
module tb_vend_sequencer;
  import food_seller_pkg::*;

  localparam int DISPENSE_CYC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [2:0] coin_value = 3'd0;
  logic       choice_valid = 1'b0;
  logic [2:0] choice = 3'd0;
  logic       cancel = 1'b0;
  logic       restock_valid = 1'b0;
  logic [2:0] restock_item = 3'd0;
  logic [2:0] item;
  logic       item_valid;
  logic [2:0] change;
  logic       change_valid;
  logic [4:0] credit;
  logic [6:0] available;
  logic [1:0] status;
  logic       busy;
  state_e     dbg_state;

  int checks = 0;
  int errors = 0;
  // Entry layout: {item_valid, change_valid, item, change}
  logic [7:0] exp_q[$];
  int stock_m [8];

  vend_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_value   (coin_value),
    .choice_valid (choice_valid),
    .choice       (choice),
    .cancel       (cancel),
    .restock_valid(restock_valid),
    .restock_item (restock_item),
    .item         (item),
    .item_valid   (item_valid),
    .change       (change),
    .change_valid (change_valid),
    .credit       (credit),
    .available    (available),
    .status       (status),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "global timeout");
  end

  // ---------------- model helpers ----------------
  function automatic logic [6:0] exp_avail();
    logic [6:0] a;
    for (int i = 1; i <= 7; i++) a[i-1] = (stock_m[i] > 0);
    return a;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 8; i++) stock_m[i] = 3;
    exp_q.delete();
  endtask

  task automatic push_item(input logic [2:0] it);
    for (int i = 0; i < DISPENSE_CYC; i++) exp_q.push_back({1'b1, 1'b0, it, 3'd0});
  endtask

  task automatic push_change(input int amount);
    int left;
    int c;
    left = amount;
    while (left > 0) begin
      c = (left > 7) ? 7 : left;
      exp_q.push_back({1'b0, 1'b1, 3'd0, 3'(c)});
      left -= c;
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: holds the strobes over one rising edge, returns at
  // the next negedge with the registered outputs of that edge visible.
  task automatic step(input logic cv, input logic [2:0] cval, input logic chv,
                      input logic [2:0] ch, input logic can, input logic rv,
                      input logic [2:0] ri);
    coin_valid = cv; coin_value = cval;
    choice_valid = chv; choice = ch;
    cancel = can;
    restock_valid = rv; restock_item = ri;
    @(negedge clk);
    coin_valid = 1'b0; coin_value = 3'd0;
    choice_valid = 1'b0; choice = 3'd0;
    cancel = 1'b0;
    restock_valid = 1'b0; restock_item = 3'd0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((dbg_state != IDLE || exp_q.size() != 0 || item_valid || change_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL %s_idle_timeout: state=%0d pending=%0d, required IDLE with no pending output",
               name, dbg_state, exp_q.size());
    end
    checks++;
    if (credit !== 5'd0) begin
      errors++;
      $display("FAIL %s_final_credit: got %0d, expected 0", name, credit);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [7:0] obs;
    logic [7:0] exp_v;
    if (!rst) begin
      obs = {item_valid, change_valid, item, change};
      if (item_valid || change_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %h, expected no output event", obs);
        end else begin
          exp_v = exp_q.pop_front();
          if (obs !== exp_v) begin
            errors++;
            $display("FAIL sb_event: got %h, expected %h", obs, exp_v);
          end
        end
      end else begin
        checks++;
        if (item !== 3'd0 || change !== 3'd0) begin
          errors++;
          $display("FAIL sb_idle_zero: item=%0d change=%0d, expected 0/0", item, change);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [17:0] got;
    repeat (2) @(negedge clk);
    got = {item, item_valid, change, change_valid, credit, status, busy};
    checks++;
    if (got !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0", got);
    end
    checks++;
    if (available !== 7'h7F) begin
      errors++;
      $display("FAIL reset_available: got %h, expected 7f", available);
    end
    #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state != IDLE || credit !== 5'd0) begin
      errors++;
      $display("FAIL reset_release: state=%0d credit=%0d, expected IDLE/0", dbg_state, credit);
    end
  endtask

  task automatic test_vend_change();
    step(1, 7, 0, 0, 0, 0, 0);
    checks++;
    if (credit !== 5'd7 || busy !== 1'b0) begin
      errors++;
      $display("FAIL vend_coin: credit=%0d busy=%b, expected 7/0", credit, busy);
    end
    push_item(3'd1);
    stock_m[1]--;
    push_change(4);
    step(0, 0, 1, 1, 0, 0, 0);
    checks++;
    if (busy !== 1'b1 || item_valid !== 1'b0) begin
      errors++;
      $display("FAIL vend_check_cycle: busy=%b item_valid=%b, expected 1/0", busy, item_valid);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (item_valid !== 1'b1 || credit !== 5'd4 || status !== STATUS_OK) begin
      errors++;
      $display("FAIL vend_latency: item_valid=%b credit=%0d status=%0d, expected 1/4/0",
               item_valid, credit, status);
    end
    wait_idle("vend");
    checks++;
    if (available !== exp_avail()) begin
      errors++;
      $display("FAIL vend_available: got %h, expected %h", available, exp_avail());
    end
  endtask

  task automatic test_no_funds();
    step(1, 5, 0, 0, 0, 0, 0);
    step(0, 0, 1, 4, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (status !== STATUS_NO_FUNDS || credit !== 5'd5) begin
      errors++;
      $display("FAIL nofunds_status: status=%0d credit=%0d, expected 2/5", status, credit);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (status !== STATUS_OK || dbg_state != COLLECT) begin
      errors++;
      $display("FAIL nofunds_flag_clear: status=%0d state=%0d, expected 0/COLLECT", status, dbg_state);
    end
    push_change(5);
    step(0, 0, 0, 0, 1, 0, 0);
    wait_idle("nofunds_cancel");
  endtask

  task automatic test_sold_out();
    for (int v = 0; v < 3; v++) begin
      step(1, 1, 0, 0, 0, 0, 0);
      push_item(3'd7);
      stock_m[7]--;
      step(0, 0, 1, 7, 0, 0, 0);
      wait_idle("soldout_vend");
      checks++;
      if (available !== exp_avail()) begin
        errors++;
        $display("FAIL soldout_available_%0d: got %h, expected %h", v, available, exp_avail());
      end
    end
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 7, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (status !== STATUS_SOLD_OUT || credit !== 5'd1) begin
      errors++;
      $display("FAIL soldout_status: status=%0d credit=%0d, expected 1/1", status, credit);
    end
    push_change(1);
    step(0, 0, 0, 0, 1, 0, 0);
    wait_idle("soldout_cancel");
    step(0, 0, 0, 0, 0, 1, 7);
    stock_m[7] = 3;
    checks++;
    if (available !== exp_avail()) begin
      errors++;
      $display("FAIL restock_available: got %h, expected %h", available, exp_avail());
    end
  endtask

  task automatic test_coin_reject();
    int exp_credit;
    logic [1:0] exp_status;
    exp_credit = 0;
    for (int c = 0; c < 5; c++) begin
      if (exp_credit + 7 <= 31) begin
        exp_credit += 7;
        exp_status = STATUS_OK;
      end else begin
        exp_status = STATUS_COIN_REJ;
      end
      step(1, 7, 0, 0, 0, 0, 0);
      checks++;
      if (credit !== 5'(exp_credit) || status !== exp_status) begin
        errors++;
        $display("FAIL coinrej_coin_%0d: credit=%0d status=%0d, expected %0d/%0d",
                 c, credit, status, exp_credit, exp_status);
      end
    end
    push_change(exp_credit);
    step(0, 0, 0, 0, 1, 0, 0);
    wait_idle("coinrej_cancel");
  endtask

  task automatic test_same_cycle();
    step(1, 1, 0, 0, 0, 0, 0);
    push_item(3'd5);
    stock_m[5]--;
    step(1, 1, 1, 5, 0, 0, 0);
    checks++;
    if (credit !== 5'd2 || dbg_state != CHECK) begin
      errors++;
      $display("FAIL samecyc_add: credit=%0d state=%0d, expected 2/CHECK", credit, dbg_state);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (credit !== 5'd0 || item_valid !== 1'b1) begin
      errors++;
      $display("FAIL samecyc_vend: credit=%0d item_valid=%b, expected 0/1", credit, item_valid);
    end
    wait_idle("samecyc");
  endtask

  task automatic test_reset_mid_dispense();
    logic [17:0] got;
    step(1, 7, 0, 0, 0, 0, 0);
    push_item(3'd1);
    stock_m[1]--;
    step(0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0);
    checks++;
    if (status !== STATUS_COIN_REJ || credit !== 5'd4 || dbg_state != DISPENSE) begin
      errors++;
      $display("FAIL middisp_coin_rej: status=%0d credit=%0d state=%0d, expected 3/4/DISPENSE",
               status, credit, dbg_state);
    end
    #2 rst = 1'b1;
    #1;
    reset_model();
    got = {item, item_valid, change, change_valid, credit, status, busy};
    checks++;
    if (got !== 18'd0 || available !== exp_avail()) begin
      errors++;
      $display("FAIL middisp_async_reset: outputs=%h available=%h, expected 0/%h",
               got, available, exp_avail());
    end
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dbg_state != IDLE || credit !== 5'd0 || change_valid !== 1'b0) begin
      errors++;
      $display("FAIL middisp_after: state=%0d credit=%0d change_valid=%b, expected IDLE/0/0",
               dbg_state, credit, change_valid);
    end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_vend_change();
    test_no_funds();
    test_sold_out();
    test_coin_reject();
    test_same_cycle();
    test_reset_mid_dispense();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d events pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
